// File: rtl/sd_card_cmd_if.sv
// Command request / confirm bundle between the card sequencers (master)
// and the SD command engine (slave).
interface sd_card_cmd_if;
    logic        i_fast_clk;
    logic        i_send_cmd;
    logic [2:0]  i_cmd_select;
    logic [31:0] i_cmd_arg;
    logic        o_confirm_pin;
    logic [7:0]  o_response_status;
    logic [31:0] o_resp_data;
    logic        o_busy;

    modport master (
        output i_fast_clk, i_send_cmd, i_cmd_select, i_cmd_arg,
        input  o_confirm_pin, o_response_status, o_resp_data, o_busy
    );

    modport slave (
        input  i_fast_clk, i_send_cmd, i_cmd_select, i_cmd_arg,
        output o_confirm_pin, o_response_status, o_resp_data, o_busy
    );
endinterface

// File: rtl/sd_card_cmd.sv
// SPI-mode SD command engine: serialises a 48-bit command frame, hunts for
// the R1 response, decodes it to a status code and optionally collects the
// OCR (CMD58). Two confirm pulses per command: frame sent, response valid.
// Optional build macro SD_CMD_CRC_EN: compute CRC7 over the header while
// shifting; otherwise the tail byte is 0x95 for CMD0 and 0xFF elsewhere.
module sd_card_cmd #(
    parameter int unsigned CLK_DIV_SLOW = 125,
    parameter int unsigned CLK_DIV_FAST = 2,
    parameter int unsigned NCR_MAX      = 8
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    sd_card_cmd_if.slave cmd,
    output logic         o_sd_sclk,
    output logic         o_sd_mosi,
    input  logic         i_sd_miso
);

    localparam int unsigned DIV_MAX = (CLK_DIV_SLOW > CLK_DIV_FAST) ? CLK_DIV_SLOW : CLK_DIV_FAST;
    localparam int unsigned DIV_W   = $clog2(DIV_MAX + 1);
    localparam int unsigned BYTE_W  = $clog2(NCR_MAX + 1);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LOAD   = 3'd1;
    localparam logic [2:0] ST_TX     = 3'd2;
    localparam logic [2:0] ST_HUNT   = 3'd3;
    localparam logic [2:0] ST_DECODE = 3'd4;
    localparam logic [2:0] ST_R3     = 3'd5;
    localparam logic [2:0] ST_TRAIL  = 3'd6;
    localparam logic [2:0] ST_DONE   = 3'd7;

    localparam logic [2:0] SEL_NONE  = 3'd0;
    localparam logic [2:0] SEL_CMD0  = 3'd1;
    localparam logic [2:0] SEL_CMD58 = 3'd6;

    logic [2:0]        state_q, state_d;
    logic [2:0]        sel_q, sel_d;
    logic [31:0]       arg_q, arg_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
    logic              sclk_q, sclk_d;
    logic              mosi_q, mosi_d;
    logic [47:0]       tx_sr_q, tx_sr_d;
    logic [5:0]        bit_cnt_q, bit_cnt_d;
    logic [BYTE_W-1:0] byte_cnt_q, byte_cnt_d;
    logic [7:0]        rx_sr_q, rx_sr_d;
    logic              confirm_q, confirm_d;
    logic [7:0]        status_q, status_d;
    logic [31:0]       resp_q, resp_d;
    logic              busy_q, busy_d;
`ifdef SD_CMD_CRC_EN
    logic [6:0]        crc_q, crc_d;
    logic [6:0]        crc_next_c;
`endif

    logic              shifting_c;
    logic              tick_c;
    logic              rise_c;
    logic              fall_c;
    logic [7:0]        tail_c;
    logic [47:0]       frame_c;

    // Map the 3-bit select to the SD command index.
    function automatic logic [5:0] cmd_index(input logic [2:0] sel);
        logic [5:0] idx;
        case (sel)
            3'd1:    idx = 6'd0;
            3'd2:    idx = 6'd16;
            3'd3:    idx = 6'd17;
            3'd4:    idx = 6'd24;
            3'd5:    idx = 6'd55;
            3'd6:    idx = 6'd58;
            3'd7:    idx = 6'd41;
            default: idx = 6'd0;
        endcase
        return idx;
    endfunction

    // R1 to shared status code; the highest set error bit wins.
    function automatic logic [7:0] r1_to_status(input logic [7:0] r1);
        logic [7:0] s;
        if (r1 == 8'h00)  s = 8'd1;
        else if (r1[6])   s = 8'd3;
        else if (r1[5])   s = 8'd4;
        else if (r1[4])   s = 8'd5;
        else if (r1[3])   s = 8'd6;
        else if (r1[2])   s = 8'd7;
        else if (r1[1])   s = 8'd8;
        else              s = 8'd2;
        return s;
    endfunction

    // SCLK runs only while a frame, response or trailer is being clocked.
    assign shifting_c = (state_q == ST_TX) || (state_q == ST_HUNT) ||
                        (state_q == ST_R3) || (state_q == ST_TRAIL);
    assign tick_c     = shifting_c && (div_cnt_q == div_q - DIV_W'(1));
    assign rise_c     = tick_c && !sclk_q;
    assign fall_c     = tick_c && sclk_q;

    // Default tail byte; with CRC enabled it is replaced after bit 39.
`ifdef SD_CMD_CRC_EN
    assign tail_c     = 8'hFF;
    assign crc_next_c = {crc_q[5:0], 1'b0} ^ ({7{tx_sr_q[47] ^ crc_q[6]}} & 7'h09);
`else
    assign tail_c     = (sel_q == SEL_CMD0) ? 8'h95 : 8'hFF;
`endif
    assign frame_c    = {2'b01, cmd_index(sel_q), arg_q, tail_c};

    // Next-state and datapath update.
    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        arg_d      = arg_q;
        div_d      = div_q;
        div_cnt_d  = div_cnt_q;
        sclk_d     = sclk_q;
        mosi_d     = mosi_q;
        tx_sr_d    = tx_sr_q;
        bit_cnt_d  = bit_cnt_q;
        byte_cnt_d = byte_cnt_q;
        rx_sr_d    = rx_sr_q;
        confirm_d  = 1'b0;
        status_d   = status_q;
        resp_d     = resp_q;
        busy_d     = busy_q;
`ifdef SD_CMD_CRC_EN
        crc_d      = crc_q;
`endif

        if (shifting_c) begin
            if (tick_c) begin
                div_cnt_d = '0;
                sclk_d    = ~sclk_q;
            end else begin
                div_cnt_d = div_cnt_q + DIV_W'(1);
            end
        end else begin
            div_cnt_d = '0;
            sclk_d    = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                mosi_d = 1'b1;
                if (cmd.i_send_cmd && (cmd.i_cmd_select != SEL_NONE)) begin
                    sel_d   = cmd.i_cmd_select;
                    arg_d   = cmd.i_cmd_arg;
                    div_d   = cmd.i_fast_clk ? DIV_W'(CLK_DIV_FAST) : DIV_W'(CLK_DIV_SLOW);
                    busy_d  = 1'b1;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                tx_sr_d   = frame_c;
                mosi_d    = frame_c[47];
                bit_cnt_d = '0;
`ifdef SD_CMD_CRC_EN
                crc_d     = '0;
`endif
                state_d   = ST_TX;
            end
            ST_TX: begin
                if (fall_c) begin
                    bit_cnt_d = bit_cnt_q + 6'd1;
                    tx_sr_d   = {tx_sr_q[46:0], 1'b1};
`ifdef SD_CMD_CRC_EN
                    if (bit_cnt_q < 6'd40) crc_d = crc_next_c;
                    if (bit_cnt_q == 6'd39) tx_sr_d[47:40] = {crc_next_c, 1'b1};
`endif
                    mosi_d    = tx_sr_d[47];
                    if (bit_cnt_q == 6'd47) begin
                        mosi_d     = 1'b1;
                        confirm_d  = 1'b1;
                        bit_cnt_d  = '0;
                        byte_cnt_d = '0;
                        state_d    = ST_HUNT;
                    end
                end
            end
            ST_HUNT: begin
                mosi_d = 1'b1;
                if (rise_c) rx_sr_d = {rx_sr_q[6:0], i_sd_miso};
                if (fall_c) begin
                    bit_cnt_d = bit_cnt_q + 6'd1;
                    if (bit_cnt_q == 6'd7) begin
                        bit_cnt_d = '0;
                        if (!rx_sr_q[7]) begin
                            state_d = ST_DECODE;
                        end else if (byte_cnt_q == BYTE_W'(NCR_MAX - 1)) begin
                            status_d = 8'd0;
                            state_d  = ST_TRAIL;
                        end else begin
                            byte_cnt_d = byte_cnt_q + BYTE_W'(1);
                        end
                    end
                end
            end
            ST_DECODE: begin
                status_d = r1_to_status(rx_sr_q);
                if ((sel_q == SEL_CMD58) && ((status_d == 8'd1) || (status_d == 8'd2)))
                    state_d = ST_R3;
                else
                    state_d = ST_TRAIL;
            end
            ST_R3: begin
                mosi_d = 1'b1;
                if (rise_c) resp_d = {resp_q[30:0], i_sd_miso};
                if (fall_c) begin
                    bit_cnt_d = bit_cnt_q + 6'd1;
                    if (bit_cnt_q == 6'd31) begin
                        bit_cnt_d = '0;
                        state_d   = ST_TRAIL;
                    end
                end
            end
            ST_TRAIL: begin
                mosi_d = 1'b1;
                if (fall_c) begin
                    bit_cnt_d = bit_cnt_q + 6'd1;
                    if (bit_cnt_q == 6'd7) begin
                        bit_cnt_d = '0;
                        state_d   = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                confirm_d = 1'b1;
                busy_d    = 1'b0;
                state_d   = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= ST_IDLE;
            sel_q      <= '0;
            arg_q      <= '0;
            div_q      <= '0;
            div_cnt_q  <= '0;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b1;
            tx_sr_q    <= '1;
            bit_cnt_q  <= '0;
            byte_cnt_q <= '0;
            rx_sr_q    <= '1;
            confirm_q  <= 1'b0;
            status_q   <= '0;
            resp_q     <= '0;
            busy_q     <= 1'b0;
`ifdef SD_CMD_CRC_EN
            crc_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            arg_q      <= arg_d;
            div_q      <= div_d;
            div_cnt_q  <= div_cnt_d;
            sclk_q     <= sclk_d;
            mosi_q     <= mosi_d;
            tx_sr_q    <= tx_sr_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            rx_sr_q    <= rx_sr_d;
            confirm_q  <= confirm_d;
            status_q   <= status_d;
            resp_q     <= resp_d;
            busy_q     <= busy_d;
`ifdef SD_CMD_CRC_EN
            crc_q      <= crc_d;
`endif
        end
    end

    assign o_sd_sclk             = sclk_q;
    assign o_sd_mosi             = mosi_q;
    assign cmd.o_confirm_pin     = confirm_q;
    assign cmd.o_response_status = status_q;
    assign cmd.o_resp_data       = resp_q;
    assign cmd.o_busy            = busy_q;

endmodule

// File: tb/tb_sd_card_cmd.sv
// Bench for sd_card_cmd: an SD card model answers on MISO, every command is
// checked against a reference model of frame, status, OCR and timing.
module tb_sd_card_cmd;
    localparam int unsigned DIV_SLOW = 125;
    localparam int unsigned DIV_FAST = 2;
    localparam int unsigned NCR      = 8;

    logic clk     = 1'b0;
    logic rst_n   = 1'b0;
    logic sd_sclk;
    logic sd_mosi;
    logic sd_miso = 1'b1;

    sd_card_cmd_if dif ();

    sd_card_cmd #(
        .CLK_DIV_SLOW (DIV_SLOW),
        .CLK_DIV_FAST (DIV_FAST),
        .NCR_MAX      (NCR)
    ) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .cmd       (dif),
        .o_sd_sclk (sd_sclk),
        .o_sd_mosi (sd_mosi),
        .i_sd_miso (sd_miso)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Observation logs, written only by the monitors below.
    int unsigned cyc      = 0;
    int          conf_cnt = 0;
    int unsigned conf_cyc[$];
    logic        conf_busy[$];
    logic [7:0]  conf_stat[$];
    int          conf_rise[$];
    int          rise_cnt = 0;
    logic        mosi_log[$];
    int          hi_log[$];
    int          hi_len   = 0;
    logic        sclk_prev = 1'b0;

    // Confirm pulses and SCLK high-phase lengths, sampled mid-cycle.
    always @(negedge clk) begin
        cyc++;
        if (dif.o_confirm_pin === 1'b1) begin
            conf_cnt++;
            conf_cyc.push_back(cyc);
            conf_busy.push_back(dif.o_busy);
            conf_stat.push_back(dif.o_response_status);
            conf_rise.push_back(rise_cnt);
        end
        if (sd_sclk === 1'b1) begin
            hi_len++;
        end else if (sclk_prev === 1'b1) begin
            hi_log.push_back(hi_len);
            hi_len = 0;
        end
        sclk_prev = sd_sclk;
    end

    // Card side: capture MOSI on each rising SCLK edge.
    always @(posedge sd_sclk) begin
        rise_cnt++;
        mosi_log.push_back(sd_mosi);
    end

    // Card side: present the next MISO bit after each falling SCLK edge.
    logic card_bits[$];
    int   card_gen      = 0;
    int   card_idx      = 0;
    int   card_last_gen = 0;
    always begin
        @(card_gen or negedge sd_sclk);
        if (card_gen != card_last_gen) begin
            card_last_gen = card_gen;
            card_idx      = 0;
        end else begin
            card_idx++;
        end
        sd_miso = (card_idx < card_bits.size()) ? card_bits[card_idx] : 1'b1;
    end

    // Reference model state.
    logic [7:0]  rsp_bytes[$];
    logic [31:0] exp_resp  = 32'h0;
    logic [7:0]  last_stat = 8'h0;

    function automatic logic [7:0] byte_at(input int i);
        return (i < rsp_bytes.size()) ? rsp_bytes[i] : 8'hFF;
    endfunction

    function automatic logic [5:0] cmd_index(input logic [2:0] sel);
        int tab[8] = '{0, 0, 16, 17, 24, 55, 58, 41};
        return 6'(tab[sel]);
    endfunction

    function automatic logic [6:0] crc7_of(input logic [39:0] h);
        logic [6:0] c = 7'h0;
        logic       fb;
        for (int i = 39; i >= 0; i--) begin
            fb = h[i] ^ c[6];
            c  = {c[5:0], 1'b0};
            if (fb) c = c ^ 7'h09;
        end
        return c;
    endfunction

    function automatic logic [47:0] exp_frame(input logic [2:0] sel, input logic [31:0] arg);
        logic [39:0] hdr;
        logic [7:0]  last;
        hdr = {8'h40 | {2'b00, cmd_index(sel)}, arg};
`ifdef SD_CMD_CRC_EN
        last = {crc7_of(hdr), 1'b1};
`else
        last = (sel == 3'd1) ? 8'h95 : 8'hFF;
`endif
        return {hdr, last};
    endfunction

    function automatic logic [7:0] r1_status(input logic [7:0] r1);
        int bit_order[7] = '{6, 5, 4, 3, 2, 1, 0};
        int code[7]      = '{3, 4, 5, 6, 7, 8, 2};
        if (r1 == 8'h00) return 8'd1;
        for (int k = 0; k < 7; k++)
            if (r1[bit_order[k]]) return 8'(code[k]);
        return 8'd1;
    endfunction

    task automatic load_card();
        logic [7:0] b;
        card_bits.delete();
        repeat (48) card_bits.push_back(1'b1);
        foreach (rsp_bytes[i]) begin
            b = rsp_bytes[i];
            for (int k = 7; k >= 0; k--) card_bits.push_back(b[k]);
        end
        card_gen++;
        #1;
    endtask

    // Issue one command and check every observable result.
    task automatic run_cmd(input logic [2:0] sel, input logic [31:0] arg, input logic fast,
                           input bit poke, input string tag);
        int          div, r1_pos, hunt, exp_rises, bound, c, gap, hmin, hmax;
        int          b_conf, b_rise, b_mosi, b_hi;
        logic [7:0]  exp_stat, bt;
        logic        r3, tail_ok;
        logic [47:0] frame, got_frame;

        div    = fast ? int'(DIV_FAST) : int'(DIV_SLOW);
        r1_pos = -1;
        for (int i = 0; i < int'(NCR); i++) begin
            bt = byte_at(i);
            if (r1_pos < 0 && bt[7] == 1'b0) r1_pos = i;
        end
        r3 = 1'b0;
        if (r1_pos < 0) begin
            exp_stat = 8'd0;
            hunt     = NCR;
        end else begin
            exp_stat = r1_status(byte_at(r1_pos));
            hunt     = r1_pos + 1;
            r3       = (sel == 3'd6) && (exp_stat == 8'd1 || exp_stat == 8'd2);
            if (r3) exp_resp = {byte_at(r1_pos + 1), byte_at(r1_pos + 2),
                                byte_at(r1_pos + 3), byte_at(r1_pos + 4)};
        end
        last_stat = exp_stat;
        exp_rises = 48 + 8 * hunt + (r3 ? 32 : 0) + 8;
        frame     = exp_frame(sel, arg);

        load_card();
        b_conf = conf_cnt;
        b_rise = rise_cnt;
        b_mosi = mosi_log.size();
        b_hi   = hi_log.size();

        @(negedge clk);
        dif.i_fast_clk   = fast;
        dif.i_cmd_select = sel;
        dif.i_cmd_arg    = arg;
        dif.i_send_cmd   = 1'b1;
        @(negedge clk);
        dif.i_send_cmd   = 1'b0;
        dif.i_cmd_select = 3'($urandom_range(0, 7));
        dif.i_cmd_arg    = $urandom;
        dif.i_fast_clk   = ~fast;

        bound = (48 + 8 * int'(NCR) + 32 + 8) * 2 * div + 200;
        c = 0;
        while (c < bound && (conf_cnt - b_conf) < 2) begin
            @(negedge clk);
            dif.i_send_cmd = (poke && c == 40) ? 1'b1 : 1'b0;
            c++;
        end
        dif.i_send_cmd = 1'b0;
        repeat (12) @(negedge clk);

        n_cmp++;
        if (conf_cnt - b_conf !== 2) begin
            n_fail++;
            $display("FAIL %s/confirm_count: got %0d expected 2", tag, conf_cnt - b_conf);
        end
        if (conf_cnt - b_conf >= 2) begin
            n_cmp++;
            if (conf_rise[b_conf] - b_rise !== 48) begin
                n_fail++;
                $display("FAIL %s/first_confirm_bit: got %0d expected 48", tag, conf_rise[b_conf] - b_rise);
            end
            n_cmp++;
            if (conf_busy[b_conf] !== 1'b1) begin
                n_fail++;
                $display("FAIL %s/busy_at_first: got %b expected 1", tag, conf_busy[b_conf]);
            end
            gap = int'(conf_cyc[b_conf + 1] - conf_cyc[b_conf]);
            n_cmp++;
            if (gap < 2) begin
                n_fail++;
                $display("FAIL %s/confirm_gap: got %0d expected >=2", tag, gap);
            end
            n_cmp++;
            if (conf_busy[b_conf + 1] !== 1'b0) begin
                n_fail++;
                $display("FAIL %s/busy_at_second: got %b expected 0", tag, conf_busy[b_conf + 1]);
            end
            n_cmp++;
            if (conf_stat[b_conf + 1] !== exp_stat) begin
                n_fail++;
                $display("FAIL %s/status: got %0d expected %0d", tag, conf_stat[b_conf + 1], exp_stat);
            end
        end

        n_cmp++;
        if (rise_cnt - b_rise !== exp_rises) begin
            n_fail++;
            $display("FAIL %s/sclk_periods: got %0d expected %0d", tag, rise_cnt - b_rise, exp_rises);
        end

        got_frame = 'x;
        if (mosi_log.size() >= b_mosi + 48)
            for (int k = 0; k < 48; k++) got_frame[47 - k] = mosi_log[b_mosi + k];
        n_cmp++;
        if (got_frame !== frame) begin
            n_fail++;
            $display("FAIL %s/frame: got %012h expected %012h", tag, got_frame, frame);
        end

        tail_ok = 1'b1;
        for (int k = b_mosi + 48; k < mosi_log.size(); k++)
            if (mosi_log[k] !== 1'b1) tail_ok = 1'b0;
        n_cmp++;
        if (tail_ok !== 1'b1) begin
            n_fail++;
            $display("FAIL %s/mosi_idle_high: got %b expected 1", tag, tail_ok);
        end

        n_cmp++;
        if (dif.o_resp_data !== exp_resp) begin
            n_fail++;
            $display("FAIL %s/resp_data: got %08h expected %08h", tag, dif.o_resp_data, exp_resp);
        end
        n_cmp++;
        if ({dif.o_busy, dif.o_response_status} !== {1'b0, exp_stat}) begin
            n_fail++;
            $display("FAIL %s/idle_after: got busy=%b status=%0d expected busy=0 status=%0d",
                     tag, dif.o_busy, dif.o_response_status, exp_stat);
        end

        hmin = -1;
        hmax = -1;
        for (int k = b_hi; k < hi_log.size(); k++) begin
            if (hmin < 0 || hi_log[k] < hmin) hmin = hi_log[k];
            if (hi_log[k] > hmax) hmax = hi_log[k];
        end
        n_cmp++;
        if (hmin != div || hmax != div) begin
            n_fail++;
            $display("FAIL %s/half_period: got min=%0d max=%0d expected %0d", tag, hmin, hmax, div);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        n_cmp++;
        if ({sd_sclk, sd_mosi, dif.o_confirm_pin, dif.o_response_status, dif.o_resp_data, dif.o_busy}
            !== {1'b0, 1'b1, 1'b0, 8'h00, 32'h0, 1'b0}) begin
            n_fail++;
            $display("FAIL %s: got sclk=%b mosi=%b conf=%b stat=%0d resp=%08h busy=%b expected 0 1 0 0 0 0",
                     tag, sd_sclk, sd_mosi, dif.o_confirm_pin, dif.o_response_status,
                     dif.o_resp_data, dif.o_busy);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        check_reset_outputs("reset_values");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_cmd0_slow();
        rsp_bytes = {8'hFF, 8'h01};
        run_cmd(3'd1, 32'h0, 1'b0, 1'b0, "cmd0_slow");
    endtask

    task automatic test_cmd55();
        rsp_bytes = {8'h00};
        run_cmd(3'd5, 32'h0, 1'b1, 1'b0, "cmd55");
    endtask

    task automatic test_cmd58_fast();
        rsp_bytes = {8'hFF, 8'h00, 8'hC0, 8'hFF, 8'h80, 8'h00};
        run_cmd(3'd6, 32'h0, 1'b1, 1'b0, "cmd58_ocr");
    endtask

    task automatic test_timeout();
        rsp_bytes = {};
        run_cmd(3'd3, 32'h200, 1'b1, 1'b0, "cmd17_timeout");
    endtask

    task automatic test_cmd41_errors();
        rsp_bytes = {8'hFF, 8'hFF, 8'h44};
        run_cmd(3'd7, 32'h4000_0000, 1'b1, 1'b1, "cmd41_param");
        rsp_bytes = {8'h0C};
        run_cmd(3'd7, 32'h4000_0000, 1'b1, 1'b1, "cmd41_crc");
    endtask

    task automatic test_select0();
        int b_conf, b_rise;
        b_conf = conf_cnt;
        b_rise = rise_cnt;
        @(negedge clk);
        dif.i_cmd_select = 3'd0;
        dif.i_send_cmd   = 1'b1;
        @(negedge clk);
        dif.i_send_cmd   = 1'b0;
        repeat (30) @(negedge clk);
        n_cmp++;
        if ({dif.o_busy, conf_cnt - b_conf, rise_cnt - b_rise} !== {1'b0, 32'd0, 32'd0}) begin
            n_fail++;
            $display("FAIL select0_ignored: got busy=%b confirms=%0d sclks=%0d expected 0 0 0",
                     dif.o_busy, conf_cnt - b_conf, rise_cnt - b_rise);
        end
        n_cmp++;
        if (dif.o_response_status !== last_stat) begin
            n_fail++;
            $display("FAIL select0_status_hold: got %0d expected %0d", dif.o_response_status, last_stat);
        end
    endtask

    task automatic test_random();
        logic [2:0] sel;
        int         nff, kind;
        logic [7:0] r1;
        for (int it = 0; it < 12; it++) begin
            sel  = 3'($urandom_range(1, 7));
            nff  = $urandom_range(0, 9);
            kind = $urandom_range(0, 3);
            r1   = (kind == 0) ? 8'h00 : (kind == 1) ? 8'h01 : 8'($urandom_range(0, 127));
            rsp_bytes = {};
            repeat (nff) rsp_bytes.push_back(8'hFF);
            rsp_bytes.push_back(r1);
            repeat (4) rsp_bytes.push_back(8'($urandom));
            run_cmd(sel, $urandom, 1'b1, bit'($urandom_range(0, 1)), $sformatf("random%0d", it));
        end
    endtask

    task automatic test_reset_mid();
        int b_conf, b_rise, c;
        rsp_bytes = {8'h01};
        load_card();
        b_conf = conf_cnt;
        b_rise = rise_cnt;
        @(negedge clk);
        dif.i_fast_clk   = 1'b1;
        dif.i_cmd_select = 3'd1;
        dif.i_cmd_arg    = 32'h0;
        dif.i_send_cmd   = 1'b1;
        @(negedge clk);
        dif.i_send_cmd   = 1'b0;
        c = 0;
        while (c < 2000 && rise_cnt - b_rise < 20) begin
            @(negedge clk);
            c++;
        end
        n_cmp++;
        if (rise_cnt - b_rise < 20) begin
            n_fail++;
            $display("FAIL reset_mid/reach_bit20: got %0d sclks expected 20", rise_cnt - b_rise);
        end
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("reset_mid_async");
        exp_resp  = 32'h0;
        last_stat = 8'h0;
        repeat (5) @(negedge clk);
        check_reset_outputs("reset_mid_held");
        n_cmp++;
        if (conf_cnt - b_conf !== 0) begin
            n_fail++;
            $display("FAIL reset_mid/no_confirm: got %0d expected 0", conf_cnt - b_conf);
        end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        rsp_bytes = {8'hFF, 8'h01};
        run_cmd(3'd1, 32'h0, 1'b1, 1'b0, "cmd0_after_reset");
    endtask

    initial begin
        dif.i_fast_clk   = 1'b0;
        dif.i_send_cmd   = 1'b0;
        dif.i_cmd_select = 3'd0;
        dif.i_cmd_arg    = 32'h0;
        test_reset();
        test_cmd0_slow();
        test_cmd55();
        test_cmd58_fast();
        test_timeout();
        test_cmd41_errors();
        test_select0();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/sd_card_cmd.md
Name: sd_card_cmd

Overview:
SPI-mode SD command engine. It is the responder to the card-init and read/write sequencers. It takes a pulsed command request with a 3-bit command select and a 32-bit argument, and serialises the 48-bit command frame on MOSI. It then hunts for the R1 response on MISO, decodes R1 into the shared status code set, and returns the result with a two-pulse confirm handshake. SD chip select is owned by the caller.

Parameters:
CLK_DIV_SLOW, 125, i_clk cycles per SCLK half-period during init (<=400 kHz)
CLK_DIV_FAST, 2, i_clk cycles per SCLK half-period after init
NCR_MAX, 8, max response-hunt bytes before timeout

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  async active-low reset
i_fast_clk  in  1  1 = use CLK_DIV_FAST; sampled only in IDLE
i_send_cmd  in  1  one-cycle request pulse
i_cmd_select  in  3  0 NO_CMD, 1 CMD0, 2 CMD16, 3 CMD17, 4 CMD24, 5 CMD55, 6 CMD58, 7 CMD41
i_cmd_arg  in  32  command argument
o_confirm_pin  out  1  one-cycle pulse: frame sent, then response valid
o_response_status  out  8  0 no_rsp, 1 no_error, 2 idle, 3 parameter, 4 address, 5 erase_seq, 6 crc, 7 illegal, 8 erase_reset
o_resp_data  out  32  OCR trailing bytes (CMD58 only)
o_busy  out  1  high from accept until final confirm
o_sd_sclk  out  1  SPI clock, mode 0
o_sd_mosi  out  1  SPI data out
i_sd_miso  in  1  SPI data in

Behaviour:
- Reset values (async, immediate): o_sd_sclk=0, o_sd_mosi=1, o_confirm_pin=0, o_response_status=0, o_resp_data=0, o_busy=0, FSM=IDLE, divider=0.
- Index map: CMD0→0, CMD16→16, CMD17→17, CMD24→24, CMD55→55, CMD58→58, CMD41→41. Frame = {0x40|index, arg[31:24..7:0], crc7,1}, MSB first.
- SPI: MOSI updates on the SCLK falling edge (first bit is set up before the first rising edge). MISO is sampled on the rising edge. SCLK toggles every DIV i_clk cycles and is low whenever the FSM is not shifting.
- FSM states:
  - IDLE: i_send_cmd=1 with select≠0 → latch select/arg/divider, o_busy=1, go to LOAD. A select of 0 is ignored.
  - LOAD: build the frame, go to TX.
  - TX: 48 SCLK periods. After the last falling edge, pulse o_confirm_pin for one cycle, MOSI=1, go to HUNT.
  - HUNT: clock in bytes with MOSI=1. The first byte with bit7=0 is R1 → DECODE. After NCR_MAX bytes with no R1, status=0 → TRAIL.
  - DECODE (one cycle): R1==0x00 → 1. Otherwise the highest set bit wins, in priority order: bit6→3, bit5→4, bit4→5, bit3→6, bit2→7, bit1→8, bit0→2. Next state is R3 if the command is CMD58 and status is 1 or 2, else TRAIL.
  - R3: shift 32 bits MSB-first into o_resp_data → TRAIL.
  - TRAIL: 8 SCLK periods with MOSI=1 → DONE.
  - DONE: o_response_status valid, pulse o_confirm_pin for one cycle, o_busy=0 → IDLE.
- Handshake: each accepted command produces exactly two confirm pulses, at least 2 cycles apart. o_response_status holds until the next DECODE or timeout. i_send_cmd while o_busy=1 is ignored.
- Arguments are latched at accept, so changing inputs mid-command has no effect.
- A reset mid-command aborts immediately with no confirm. The next command after reset runs normally.
- Only select 6 (CMD58) updates o_resp_data; for all other selects it holds its previous value.

Optional Feature:
SD_CMD_CRC_EN:
- Defined: CRC7 (poly x^7+x^3+1, init 0) is computed serially over the 40 header bits during TX, and the last byte is {crc7,1}.
- Undefined: the CRC engine is omitted. The last byte is 0x95 for CMD0 and 0xFF for all other commands.

Test Plan:
1. CMD0, arg 0, slow divider, MISO returns 0xFF,0x01 → MOSI bytes 40 00 00 00 00 95. First confirm after the 48th bit; second confirm with status=2; o_busy falls with the second confirm.
2. CMD55, arg 0, with SD_CMD_CRC_EN defined, R1=0x00 → last frame byte 0x65, status=1. Without the macro → last byte 0xFF.
3. CMD58, i_fast_clk=1, R1=0x00 then C0 FF 80 00 → SCLK half-period = 2 cycles, o_resp_data=0xC0FF8000, status=1.
4. CMD17, arg 0x200, MISO held 1, NCR_MAX=8 → after 8 hunt bytes and the trail, status=0, second confirm is issued, o_resp_data unchanged.
5. CMD41 with R1=0x44 → status=3; R1=0x0C → status=6; i_send_cmd pulsed mid-command is ignored (still exactly two confirms).
6. i_rst_n low during TX bit 20 → outputs take reset values asynchronously, no confirm; a following CMD0 completes normally.
